param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_mem_dp.sv | 28 ++
 rtl/param_sync_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers, read-mode constants and parameter legality rules
// for the synchronous FIFO and its storage.
package fifo_pkg;

  // Values accepted by the FWFT parameter.
  localparam int unsigned FWFT_REGISTERED  = 0;
  localparam int unsigned FWFT_FALLTHROUGH = 1;

  // Pointer width: enough bits to address every entry.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one more bit than the pointer so a full FIFO is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

  // True when the parameter set describes a buildable FIFO.
  function automatic bit params_legal(input int unsigned dw,
                                      input int unsigned depth,
                                      input int unsigned af,
                                      input int unsigned ae,
                                      input int unsigned fwft);
    return (dw >= 1) && (dw <= 64) &&
           (depth >= 4) && (depth <= 1024) && ((depth & (depth - 1)) == 0) &&
           (af <= depth) && (ae < af) &&
           ((fwft == FWFT_REGISTERED) || (fwft == FWFT_FALLTHROUGH));
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word on an enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointer/count control, status flags and
// either registered or first-word-fall-through read data.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = FWFT_REGISTERED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         almostfull,
  output logic                         empty,
  output logic                         almostempty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  if (!params_legal(DATA_WIDTH, FIFO_DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $fatal(1, "param_sync_fifo: illegal parameters (depth must be a power of two 4..1024, AF_LEVEL<=FIFO_DEPTH, AE_LEVEL<AF_LEVEL)");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full_c, empty_c;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full_c      = (count_q == DEPTH_C);
  assign empty_c     = (count_q == '0);
  assign wr_accept   = wr_en & ~full_c;
  assign rd_accept   = rd_en & ~empty_c;

  assign full        = full_c;
  assign empty       = empty_c;
  assign almostfull  = (count_q >= AF_C) && !full_c;
  assign almostempty = (count_q <= AE_C) && !empty_c;
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Next pointer/occupancy state and the one-cycle handshake pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = wr_en & ~wr_accept;
    underflow_d = rd_en & ~rd_accept;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset wins over a simultaneous write, so storage is never touched during reset.
  fifo_mem_dp #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept & ~rst),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
    assign data_out   = rd_data;
    assign data_valid = ~empty_c;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;

    // Capture the head word on an accepted read; hold it otherwise.
    always_comb begin
      dout_d   = dout_q;
      dvalid_d = rd_accept;
      if (rd_accept) dout_d = rd_data;
    end

    // Registered read-data stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
  end

endmodule
